muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin the operation in op.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_val  input  DATA_WIDTH  operand A (multiplicand / dividend), taken from the GPR Rs read port.
REQ-007 SHALL have port rt_val  input  DATA_WIDTH  operand B (multiplier / divisor), taken from the GPR Rt read port.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port mthi  input  1  write rs_val into HI.
REQ-010 SHALL have port mtlo  input  1  write rs_val into LO.
REQ-011 SHALL have port busy  output  1  operation in flight; the pipeline stalls MFHI/MFLO/MT*/start on it.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  DATA_WIDTH  HI register, driven to the GPR write-data mux for MFHI.
REQ-014 SHALL have port lo  output  DATA_WIDTH  LO register, driven to the GPR write-data mux for MFLO.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FIX; busy=1 in RUN and FIX, otherwise 0.
REQ-016 In IDLE, start=1 SHALL latch op, rs_val and rt_val, load the iteration counter with DATA_WIDTH-1, and enter RUN.
REQ-017 start, mthi and mtlo SHALL be ignored while busy=1.
REQ-018 RUN SHALL perform one iteration per cycle (radix-2 shift-add multiply or restoring divide on magnitudes), decrement the counter, and enter FIX after the iteration at counter 0.
REQ-019 FIX SHALL apply sign correction, write HI/LO, return to IDLE, and register done=1 for exactly one cycle.
REQ-020 Latency: done=1 and the new HI/LO SHALL be visible DATA_WIDTH+2 rising edges after the edge that samples start (34 at the default).
REQ-021 Multiply: {HI,LO} SHALL be the full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-022 Divide: LO SHALL be the quotient truncated toward zero and HI the remainder carrying the sign of the dividend.
REQ-023 Divide by zero SHALL give LO=magnitude-quotient all-ones before sign fix and HI=dividend; DIVU x/0 SHALL give LO=0xFFFFFFFF, HI=x.
REQ-024 DIV 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-025 flush=1 SHALL return the FSM to IDLE on the next edge with HI/LO unchanged and no done pulse; flush has priority over a simultaneous start.
REQ-026 mthi/mtlo in IDLE SHALL update HI/LO on the same edge; if start is also asserted on that edge, the write SHALL occur and the operation result SHALL later overwrite it.
REQ-027 Operand changes on rs_val/rt_val after the accepting edge SHALL NOT affect the result.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, including mid-operation; no done pulse SHALL follow.
REQ-029 The first start SHALL be accepted on the first rising edge with reset=0.

Configuration
REQ-030 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-031 With MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL compute the product with a single-cycle multiplier and go IDLE->FIX directly, with done 2 edges after start; divide SHALL be unchanged.
REQ-032 Without MULDIV_FAST_MUL_EN, multiply SHALL use the iterative RUN path with the REQ-020 latency and no hardware multiplier inferred.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> done at edge 34, HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high edges 1..33.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 MTHI 0x12345678, then DIVU 100/7 -> HI=0x12345678 before done; HI=2, LO=14 after done; start pulses while busy are ignored.
REQ-037 Assert flush at edge 10 of a MULTU, then reset at edge 5 of a DIV -> no done, busy drops immediately, HI/LO held across flush and zeroed by reset.
REQ-038 With MULDIV_FAST_MUL_EN: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at edge 2, HI=0xFFFFFFFE, LO=0x00000001.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Multiply and divide run one radix-2 iteration per cycle on operand magnitudes.
// The sign of the result is applied in a final FIX cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle product and go
// straight from IDLE to FIX. Divide timing is the same in both builds.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    input  logic                  flush,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    // Working register: upper half is the partial product or the remainder.
    // Lower half is the multiplier or the dividend, which shifts out as quotient bits shift in.
    logic [2*W-1:0]  work_q;
    logic [2*W-1:0]  work_d;
    logic [W-1:0]    b_q;
    logic            div_q;
    logic            neg_q;
    logic            dsgn_q;

    // Two's-complement negate when neg is set; magnitudes and sign fix share it.
    function automatic logic [W-1:0] sfix_w(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*W-1:0] sfix_2w(input logic [2*W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            accept;
    logic            fast_mul;
    logic [2*W-1:0]  load_val;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & rs_val[W-1];
    assign b_neg     = is_signed & rt_val[W-1];
    assign a_mag     = sfix_w(rs_val, a_neg);
    assign b_mag     = sfix_w(rt_val, b_neg);
    assign accept    = (state_q == IDLE) && start && !flush;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul  = ~op[1];
    assign load_val  = op[1] ? {{W{1'b0}}, a_mag}
                             : ({{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag});
`else
    assign fast_mul  = 1'b0;
    assign load_val  = {{W{1'b0}}, a_mag};
`endif

    logic [W:0]      add_sum;
    logic [W:0]      shl_rem;
    logic [W-1:0]    sub_diff;
    logic            ge;

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        add_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        shl_rem  = work_q[2*W-1:W-1];
        sub_diff = shl_rem[W-1:0] - b_q;
        ge       = (shl_rem >= {1'b0, b_q});
        work_d   = work_q;
        if (div_q) begin
            work_d = {(ge ? sub_diff : shl_rem[W-1:0]), work_q[W-2:0], ge};
        end else begin
            work_d = {add_sum, work_q[W-1:1]};
        end
    end

    logic [2*W-1:0]  res_prod;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Sign correction: the product and quotient take the operand sign XOR; the remainder takes the dividend sign
    always_comb begin
        res_prod = sfix_2w(work_q, neg_q);
        if (div_q) begin
            res_hi = sfix_w(work_q[2*W-1:W], dsgn_q);
            res_lo = sfix_w(work_q[W-1:0], neg_q);
        end else begin
            res_hi = res_prod[2*W-1:W];
            res_lo = res_prod[W-1:0];
        end
    end

    // Datapath registers: latch operands on accept, iterate while running
    always_ff @(posedge clk) begin
        if (accept) begin
            work_q <= load_val;
            b_q    <= b_mag;
            div_q  <= op[1];
            neg_q  <= a_neg ^ b_neg;
            dsgn_q <= a_neg;
        end else if (state_q == RUN) begin
            work_q <= work_d;
        end
    end

    // Control FSM with registered busy/done and the architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= rs_val;
                    if (mtlo) lo_q <= rs_val;
                    if (accept) begin
                        cnt_q   <= CW'(W - 1);
                        state_q <= fast_mul ? FIX : RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (cnt_q == '0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with an expected-result queue, plus
// sequences for MTHI/MTLO interaction, ignored starts, flush and mid-operation reset.
// The expected latency follows MULDIV_FAST_MUL_EN when the bench is built with it.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    function automatic int exp_lat(input logic [1:0] o);
        return (FAST_EN && !o[1]) ? 2 : 34;
    endfunction

    // Drive start for one edge; that edge is edge 1. Operands are scrambled afterwards.
    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        edge_n = 1;
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic launch(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.name = name;
        e.ehi  = ehi;
        e.elo  = elo;
        e.lat  = exp_lat(o);
        sb.push_back(e);
        drive_start(o, a, b);
    endtask

    task automatic finish_op();
        exp_t e;
        while (!done && edge_n < 100) tick();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: done seen with empty queue, required a pending entry");
        end else begin
            e = sb.pop_front();
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL %s done: none within %0d edges, required done", e.name, edge_n);
            end else begin
                check({e.name, " latency"}, 64'(edge_n), 64'(e.lat));
                check({e.name, " hi"}, hi, e.ehi);
                check({e.name, " lo"}, lo, e.elo);
                check({e.name, " busy at done"}, busy, 1'b0);
                tick();
                check({e.name, " done width"}, done, 1'b0);
            end
        end
    endtask

    task automatic no_done_window(input string name, input int n);
        int c = 0;
        repeat (n) begin
            tick();
            if (done) c++;
        end
        check(name, 64'(c), 64'd0);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{"mult_neg2x3",    MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{"multu_max",      MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2]  = '{"mult_min_min",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[3]  = '{"mult_7xneg1",    MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        tbl[4]  = '{"div_neg7_2",     DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[5]  = '{"divu_7_0",       DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        tbl[6]  = '{"div_min_neg1",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[7]  = '{"div_neg7_0",     DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        tbl[8]  = '{"div_7_neg2",     DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[9]  = '{"multu_ffff",     MULTU, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};
        tbl[10] = '{"divu_big_2",     DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        op     = MULT;
        rs_val = '0;
        rt_val = '0;
        tick();
        tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        reset = 1'b0;

        // The first vector starts on the first edge with reset low
        for (int i = 0; i < 11; i++) begin
            launch(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);
            check({tbl[i].name, " busy after start"}, busy, 1'b1);
            finish_op();
        end

        // MTHI, then DIVU 100/7 with an ignored start and MTHI while busy
        rs_val = 32'h12345678;
        mthi   = 1'b1;
        tick();
        mthi = 1'b0;
        check("mthi write", hi, 32'h12345678);
        launch("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        while (edge_n < 4) tick();
        op     = MULT;
        rs_val = 32'h00000005;
        rt_val = 32'h00000005;
        start  = 1'b1;
        mthi   = 1'b1;
        tick();
        start  = 1'b0;
        mthi   = 1'b0;
        check("busy start ignored", busy, 1'b1);
        check("hi before done", hi, 32'h12345678);
        finish_op();
        no_done_window("no extra done after ignored start", 40);

        // MTLO on the same edge as start: write lands, then the result overwrites it
        mtlo = 1'b1;
        launch("divu_mtlo", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        mtlo = 1'b0;
        check("mtlo with start", lo, 32'd100);
        finish_op();

        // Flush at edge 10 of a MULTU: HI/LO held, no done
        drive_start(MULTU, 32'h00001234, 32'h00005678);
        while (edge_n < 9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", busy, 1'b0);
        check("flush hi held", hi, 32'd2);
        check("flush lo held", lo, 32'd14);
        no_done_window("flush no done", 40);
        check("flush hi after", hi, 32'd2);

        // Flush wins over a simultaneous start
        flush = 1'b1;
        drive_start(DIV, 32'd9, 32'd3);
        flush = 1'b0;
        check("flush beats start", busy, 1'b0);

        // Reset asserted between edges 4 and 5 of a DIV
        drive_start(DIV, 32'd100, 32'd7);
        while (edge_n < 4) tick();
        #2;
        reset = 1'b1;
        #1;
        check("reset mid busy", busy, 1'b0);
        check("reset mid hi", hi, 32'h0);
        check("reset mid lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        no_done_window("reset no done", 40);
        check("reset lo held", lo, 32'h0);

        // Normal operation after the mid-operation reset
        launch("mult_after_reset", MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        finish_op();
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
